// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } ps2_state_t;

    localparam int   PS2_DATA_BITS      = 8;
    localparam int   PS2_FRAME_BITS     = 11;
    localparam logic PS2_START_BIT      = 1'b0;
    localparam logic PS2_STOP_BIT       = 1'b1;
    localparam int   PS2_FILTER_LEN_DEF = 8;
    localparam int   PS2_TIMEOUT_DEF    = 5000;

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic ps2_parity_ok(
        input logic [PS2_DATA_BITS-1:0] d,
        input logic                     p
    );
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_filter.sv
// Pin synchronisers, ps2_clk glitch filter and filtered falling-edge pulse.
module ps2_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_data,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_clk_meta;
    logic          r_clk_sync;
    logic          r_dat_meta;
    logic          r_dat_sync;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    logic          r_fall;

    // Counter never passes FILTER_LEN-1: it clears on agreement or on a level change.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_filt     <= 1'b1;
            r_cnt      <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= i_ps2_data;
            r_dat_sync <= r_dat_meta;
            r_fall     <= 1'b0;
            if (r_clk_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_sync;
                r_cnt  <= '0;
                r_fall <= r_filt;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_data = r_dat_sync;
    assign o_fall = r_fall;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host frame receiver: FSM, shift register, parity and watchdog.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF,
    parameter int TIMEOUT    = PS2_TIMEOUT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       strobe,
    output logic       frame_err
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int BCW = $clog2(PS2_DATA_BITS + 1);

    logic                     w_data;
    logic                     w_fall;
    ps2_state_t               r_state;
    logic [BCW-1:0]           r_bitcnt;
    logic [PS2_DATA_BITS-1:0] r_shreg;
    logic                     r_par;
    logic [WDW-1:0]           r_wd;
    logic [7:0]               r_scancode;
    logic                     r_strobe;
    logic                     r_err;

    ps2_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clock     (clock),
        .reset     (reset),
        .i_ps2_clk (ps2_clk),
        .i_ps2_data(ps2_data),
        .o_data    (w_data),
        .o_fall    (w_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
            r_par      <= 1'b0;
            r_wd       <= '0;
            r_scancode <= 8'h00;
            r_strobe   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_err    <= 1'b0;

            if (w_fall || r_state == S_IDLE)
                r_wd <= '0;
            else if (r_wd != WDW'(TIMEOUT))
                r_wd <= r_wd + WDW'(1);

            // A fall in the expiry cycle takes priority over the watchdog.
            if (!w_fall && r_state != S_IDLE && r_wd == WDW'(TIMEOUT)) begin
                r_state <= S_IDLE;
            end else if (w_fall) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_data == PS2_START_BIT) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shreg  <= {w_data, r_shreg[PS2_DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + BCW'(1);
                        if (r_bitcnt == BCW'(PS2_DATA_BITS - 1))
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= w_data;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (w_data == PS2_STOP_BIT && ps2_parity_ok(r_shreg, r_par)) begin
                            r_scancode <= r_shreg;
                            r_strobe   <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign scancode  = r_scancode;
    assign strobe    = r_strobe;
    assign frame_err = r_err;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx with a scaled PS/2 clock and short watchdog.
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TO   = 400;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       strobe;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int n_strobe = 0;
    int n_err = 0;
    int n_both = 0;

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clock    (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .scancode (scancode),
        .strobe   (strobe),
        .frame_err(frame_err)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (strobe) n_strobe++;
        if (frame_err) n_err++;
        if (strobe && frame_err) n_both++;
    end

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        logic [7:0] exp_code;
        int         exp_strobe;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_cnt();
        @(negedge clk);
        n_strobe = 0;
        n_err = 0;
        n_both = 0;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ pflip);
        ps2_bit(stop);
        ps2_data = 1'b1;
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        cyc(FL - 1);
        ps2_clk = 1'b1;
        cyc(20);
    endtask

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0};
        vecs[1] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1, 0};
        vecs[2] = '{8'h1C, 1'b1, 1'b1, 8'h5A, 0, 1};
        vecs[3] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0};
        vecs[4] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0};
        vecs[5] = '{8'hAA, 1'b0, 1'b0, 8'h1C, 0, 1};

        cyc(4);
        reset = 1'b0;
        cyc(2);
        chk("reset_scancode", 32'(scancode), 32'h00);
        chk("reset_strobe", 32'(strobe), 32'h0);
        chk("reset_err", 32'(frame_err), 32'h0);
        chk("reset_state", 32'(dut.r_state), 32'(S_IDLE));

        for (int v = 0; v < 6; v++) begin
            clear_cnt();
            send_frame(vecs[v].data, vecs[v].par_flip, vecs[v].stop);
            cyc(200);
            chk($sformatf("vec%0d_code", v), 32'(scancode), 32'(vecs[v].exp_code));
            chk($sformatf("vec%0d_strobes", v), n_strobe, vecs[v].exp_strobe);
            chk($sformatf("vec%0d_errs", v), n_err, vecs[v].exp_err);
        end

        // Glitches while idle and inside a frame, then finish a clean 0x29.
        clear_cnt();
        glitch();
        chk("glitch_idle_state", 32'(dut.r_state), 32'(S_IDLE));
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(((8'h29 >> i) & 8'h01) != 0);
        glitch();
        chk("glitch_frame_state", 32'(dut.r_state), 32'(S_DATA));
        chk("glitch_frame_bits", 32'(dut.r_bitcnt), 32'd4);
        for (int i = 4; i < 8; i++) ps2_bit(((8'h29 >> i) & 8'h01) != 0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        cyc(200);
        chk("glitch_code", 32'(scancode), 32'h29);
        chk("glitch_strobes", n_strobe, 1);
        chk("glitch_errs", n_err, 0);

        // Watchdog: abandon a 4-bit partial frame.
        clear_cnt();
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        cyc(TO - 100);
        chk("to_before_state", 32'(dut.r_state), 32'(S_DATA));
        cyc(110);
        chk("to_after_state", 32'(dut.r_state), 32'(S_IDLE));
        chk("to_strobes", n_strobe, 0);
        chk("to_errs", n_err, 0);
        clear_cnt();
        send_frame(8'h12, 1'b0, 1'b1);
        cyc(200);
        chk("to_next_code", 32'(scancode), 32'h12);
        chk("to_next_strobes", n_strobe, 1);

        // Reset after 5 bits drops the partial frame silently.
        clear_cnt();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
        chk("rst_code", 32'(scancode), 32'h00);
        chk("rst_state", 32'(dut.r_state), 32'(S_IDLE));
        cyc(200);
        chk("rst_strobes", n_strobe, 0);
        chk("rst_errs", n_err, 0);
        send_frame(8'h66, 1'b0, 1'b1);
        cyc(200);
        chk("rst_next_code", 32'(scancode), 32'h66);
        chk("rst_next_strobes", n_strobe, 1);
        chk("never_both", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver: synchronises and filters the external `ps2_clk`/`ps2_data` pins and deserialises 11-bit device-to-host frames. Each valid frame is delivered as a raw 8-bit scancode with a one-cycle strobe. It sits directly upstream of `scancode_convert` and drives its `scancode`/`strobe_in` inputs in the 25 MHz domain. Receive-only; host-to-device transmit is out of scope.

## Interface
- `FILTER_LEN`, 8: consecutive equal samples of synchronised `ps2_clk` required before the filtered clock changes level.
- `TIMEOUT`, 5000: `clock` cycles (200 µs at 25 MHz) without a filtered falling edge after which a partial frame is abandoned.
- `clock`  in  1  system clock; the single clock of the block.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `scancode`  out  8  last valid received byte; held between frames.
- `strobe`  out  1  one-cycle pulse: `scancode` is new.
- `frame_err`  out  1  one-cycle pulse: frame discarded (parity or stop error).

## Operation
- **Input conditioning**
  - Both pins pass through 2-FF synchronisers.
  - Synchronised `ps2_clk` feeds a filter counter. The filtered level changes only after `FILTER_LEN` consecutive samples differ from the current filtered level; any agreeing sample clears the counter.
  - The filtered level resets to 1.
  - A filtered falling edge (1→0) produces internal `fall`, one cycle wide.
  - Data is sampled from synchronised `ps2_data` in the `fall` cycle.
- **Frame format:** start=0, d0..d7 LSB first, odd parity, stop=1.
- **States**
  - IDLE: on `fall` with data=0, go to DATA, bit count=0. On `fall` with data=1, stay in IDLE, no error.
  - DATA: on `fall`, shift the bit into `shreg[7]` (right shift) and increment the count. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, store the parity bit and go to STOP.
  - STOP: on `fall`, return to IDLE.
    - Frame is valid if stop=1 and ^{shreg, parity}=1. Then load `scancode` from `shreg` and pulse `strobe` for one cycle.
    - Otherwise pulse `frame_err` and leave `scancode` unchanged.
- **Watchdog**
  - The counter clears on every `fall` and in IDLE.
  - In any non-IDLE state, reaching `TIMEOUT` forces IDLE and discards the partial data.
  - A timeout produces no `frame_err` and no `strobe`.
- `strobe` and `frame_err` never assert in the same cycle.
- **Reset values:** `scancode`=0x00, `strobe`=0, `frame_err`=0, state=IDLE, synchroniser and filtered clock=1, all counters=0.
- **Reset mid-frame:** the partial frame is dropped silently. The first frame after reset is decoded normally.

## Timing
- Pin-to-`fall` latency: 2 synchroniser cycles plus `FILTER_LEN` filter cycles after the pin's falling edge.
- `strobe`/`frame_err` assert in the cycle after the `fall` that samples the stop bit. Both are registered outputs.
- `scancode` updates in the same cycle `strobe` asserts and stays stable until the next valid frame.
- No back-pressure. Frames are at least ~60 µs apart, so the consumer must accept `strobe` unconditionally.
- **Timeout boundary:**
  - A `fall` arriving in the same cycle the counter reaches `TIMEOUT` wins: the bit is accepted and the counter clears.
  - When the watchdog expires, the state is IDLE in the next cycle.
- **Counter widths:** `$clog2(FILTER_LEN+1)` and `$clog2(TIMEOUT+1)`. Counters saturate rather than wrap.

## Structure
- **Shared package `ps2_pkg`:** state enum (IDLE, DATA, PARITY, STOP), `PS2_DATA_BITS`=8, frame-bit constants, and the default `FILTER_LEN` and `TIMEOUT` values.
- **Sub-module `ps2_filter`:** 2-FF synchronisers plus the clock filter and falling-edge detector. Outputs synchronised data and `fall`.
- The top module holds the FSM, shift register, parity check, watchdog and output registers.

## Test plan
1. **Valid frame:** 0x1C with parity=0 and stop=1, 12 kHz PS/2 clock. Expect `scancode`=0x1C, `strobe` high for exactly 1 cycle, `frame_err` never asserted.
2. **Bad parity:** 0x1C with parity=1 after a good 0x5A. Expect `frame_err` for 1 cycle, no `strobe`, `scancode` held at 0x5A.
3. **Back-to-back frames plus stop error:**
   - 0xF0 then 0x1C, 100 µs apart: two strobes with `scancode` 0xF0 then 0x1C.
   - A frame with stop=0: `frame_err` pulse, no `strobe`.
4. **Glitch rejection:**
   - `ps2_clk` low pulses of `FILTER_LEN`-1 cycles while idle and inside a frame: no state change, no output.
   - A subsequent clean 0x29 frame decodes correctly.
5. **Timeout:** 4 bits sent, then idle for `TIMEOUT`+10 cycles. Expect no `strobe` and no `frame_err`, state=IDLE. The next 0x12 frame yields `scancode`=0x12.
6. **Reset mid-frame:** `reset` asserted for 1 cycle after 5 bits. Expect `scancode`=0x00 and no pulses; the next 0x66 frame yields one `strobe` with `scancode`=0x66.
